mux16_sel_arbiter: RTL and testbench
====================================

Name: mux16_sel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 16:1 32-bit word mux.
- Picks one of 16 requesting sources and drives the mux select (sel[3:0]) with a valid/ready handshake toward the consumer of the mux output.
- Keeps sel stable for the whole transfer, so the muxed word is guaranteed steady while valid is high.
- Includes a stall timeout so one stuck transfer cannot lock out the other 15 sources.

Parameters:
- TIMEOUT, 255: number of consecutive valid-without-ready cycles before the grant is aborted. 0 disables the timeout.
- CW, 8: width of the stall counter. Must satisfy TIMEOUT <= 2^CW - 1.

Ports:
- clock  input  1  single rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  16  request vector; bit i means source i wants its word muxed out.
- ready  input  1  downstream accepts the muxed word this cycle.
- sel  output  4  select to the 16:1 mux; index of the granted source.
- valid  output  1  sel and the muxed word are valid.
- grant  output  16  one-hot copy of sel while valid; all zero otherwise.
- timeout  output  1  one-cycle pulse: the previous grant was aborted by timeout.

Behaviour:
- Reset (asynchronous, takes effect immediately without a clock edge):
  - sel=0, valid=0, grant=0, timeout=0.
  - Round-robin pointer ptr=0, stall counter cnt=0, state IDLE.
- Winner function win(v, p): first index i scanning p, p+1, ..., 15, 0, ..., p-1 (mod 16) with v[i]=1.
- IDLE:
  - If req != 0: on the next edge go to GRANT with sel=win(req, ptr), grant=1<<sel, valid=1, cnt=0. Latency from req to valid is exactly 1 cycle.
  - Otherwise stay in IDLE with valid=0, grant=0. sel holds its last value.
- GRANT with valid=1 and ready=1 (accept):
  - ptr <= (sel+1) mod 16; sel=15 wraps ptr to 0.
  - Next candidate vector n = req & ~grant (the current winner is excluded from this cycle).
  - If n != 0: stay in GRANT with sel=win(n, new ptr), grant updated, cnt=0. Back-to-back transfer, no bubble.
  - If n == 0: go to IDLE, valid=0, grant=0.
  - A sole requester holding req high is therefore granted every other cycle.
- GRANT with ready=0:
  - sel, grant and valid are held unchanged.
  - Held even if req[sel] drops; a grant is never withdrawn by the requester.
  - cnt increments by 1.
- Timeout (TIMEOUT != 0):
  - Triggers when ready=0 and cnt == TIMEOUT-1, i.e. this is the TIMEOUT-th consecutive stalled cycle.
  - The edge ending that cycle is treated as an accept (same ptr update and next-winner rule).
  - Additionally, timeout=1 for exactly the following cycle.
- ready=1 in the cycle timeout would trigger: the accept wins and no timeout pulse is generated.
- ready while valid=0 is ignored.
- cnt saturates and never wraps; it resets to 0 on every new grant.
- timeout is 0 in all cycles other than the pulse.

Test Plan:
- Reset, then req=0x8001 held, ready=1 held: valid stays 1 from cycle 1; sel sequence 0,15,0,15; grant alternates 0x0001/0x8000; ptr wrap from 15 to 0 is exercised.
- req=0x0010 held, ready=1 held: valid pattern 1,0,1,0; sel=4 and grant=0x0010 whenever valid=1.
- TIMEOUT=4, req=0x0006, ready=0: sel=1 valid for 4 cycles, then sel=2 with timeout=1 for one cycle; after 4 more stalled cycles sel=1 with timeout=1.
- TIMEOUT=4, req=0x0006, ready=0 for 3 cycles then ready=1 in the 4th stalled cycle: sel advances 1->2, timeout stays 0.
- Grant sel=3 with ready=0, req drops to 0x0000 for 5 cycles: sel=3, valid=1, grant=0x0008 held; then ready=1 -> IDLE with valid=0 and grant=0.
- reset_n pulled low mid-grant (sel=7, valid=1) between clock edges: valid, grant and timeout go to 0 and sel goes to 0 immediately; after release with req=0x0080, valid=1 and sel=7 one cycle later.

Source files
------------

// File: rtl/mux16_sel_arbiter_if.sv
// Request/select handshake between the 16 sources, the arbiter and the mux consumer.
// master = arbiter side (drives sel/valid/grant/timeout), slave = environment side.
interface mux16_sel_arbiter_if;
    logic [15:0] req;
    logic        ready;
    logic [3:0]  sel;
    logic        valid;
    logic [15:0] grant;
    logic        timeout;

    modport master (
        input  req,
        input  ready,
        output sel,
        output valid,
        output grant,
        output timeout
    );

    modport slave (
        output req,
        output ready,
        input  sel,
        input  valid,
        input  grant,
        input  timeout
    );
endinterface

// File: rtl/mux16_sel_arbiter.sv
// Round-robin 16-source select arbiter for the 16:1 word mux; req to valid in 1 cycle.
// sel/grant held while ready is low; a stall of TIMEOUT cycles forces a hand-over.
module mux16_sel_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    mux16_sel_arbiter_if.master  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_t        state_q;
    logic [3:0]    sel_q;
    logic [3:0]    ptr_q;
    logic          valid_q;
    logic          timeout_q;
    logic [15:0]   grant_q;
    logic [CW-1:0] cnt_q;

    logic          stall_to;
    logic          done;
    logic [3:0]    ptr_d;
    logic [15:0]   next_req;
    logic [3:0]    pick_idle;
    logic [3:0]    pick_next;

    // First requester found scanning upward from p, wrapping through 15 back to 0.
    function automatic logic [3:0] win(input logic [15:0] v, input logic [3:0] p);
        logic [3:0] res;
        logic [3:0] idx;
        logic       found;
        res   = p;
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            idx = p + 4'(k);
            if (v[idx] && !found) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        stall_to  = (TIMEOUT != 0) && !bus.ready && (cnt_q == CNT_LAST);
        done      = bus.ready || stall_to;
        ptr_d     = sel_q + 4'd1;
        next_req  = bus.req & ~grant_q;
        pick_idle = win(bus.req, ptr_q);
        pick_next = win(next_req, ptr_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sel_q     <= 4'd0;
            ptr_q     <= 4'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            grant_q   <= 16'd0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (|bus.req) begin
                        state_q <= GRANT;
                        sel_q   <= pick_idle;
                        grant_q <= 16'(1) << pick_idle;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        valid_q <= 1'b0;
                        grant_q <= 16'd0;
                    end
                end
                GRANT: begin
                    // A timeout hand-over follows exactly the same path as a real accept.
                    if (done) begin
                        ptr_q     <= ptr_d;
                        timeout_q <= stall_to;
                        if (|next_req) begin
                            sel_q   <= pick_next;
                            grant_q <= 16'(1) << pick_next;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            grant_q <= 16'd0;
                        end
                    end else begin
                        timeout_q <= 1'b0;
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.sel     = sel_q;
    assign bus.valid   = valid_q;
    assign bus.grant   = grant_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mux16_sel_arbiter.sv
// Two arbiters (TIMEOUT=4 and TIMEOUT=255) share one stimulus stream; a behavioural
// model pushes expected outputs per cycle and they are popped and compared mid-cycle.
module tb_mux16_sel_arbiter;

    typedef struct packed {
        logic [3:0]  sel;
        logic        valid;
        logic [15:0] grant;
        logic        timeout;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [15:0] req;
    logic        ready;

    int n_vec = 0;
    int n_err = 0;

    exp_t sb_q[$];

    int tov    [2] = '{4, 255};
    int m_busy [2];
    int m_sel  [2];
    int m_ptr  [2];
    int m_cnt  [2];
    int m_to   [2];

    mux16_sel_arbiter_if bus0();
    mux16_sel_arbiter_if bus1();

    assign bus0.req   = req;
    assign bus0.ready = ready;
    assign bus1.req   = req;
    assign bus1.ready = ready;

    mux16_sel_arbiter #(.TIMEOUT(4), .CW(8)) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    mux16_sel_arbiter #(.TIMEOUT(255), .CW(8)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int pick(input logic [15:0] v, input int p);
        for (int k = 0; k < 16; k++) begin
            if (v[(p + k) % 16]) return (p + k) % 16;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0;
            m_sel[d]  = 0;
            m_ptr[d]  = 0;
            m_cnt[d]  = 0;
            m_to[d]   = 0;
        end
    endtask

    task automatic model_step(input int d);
        logic [15:0] n;
        if (m_busy[d] == 0) begin
            m_to[d] = 0;
            if (req != 16'd0) begin
                m_sel[d]  = pick(req, m_ptr[d]);
                m_busy[d] = 1;
                m_cnt[d]  = 0;
            end
        end else if (ready || (m_cnt[d] + 1 == tov[d])) begin
            m_to[d]  = ready ? 0 : 1;
            m_ptr[d] = (m_sel[d] + 1) % 16;
            n = req & ~(16'(1) << m_sel[d]);
            if (n != 16'd0) begin
                m_sel[d] = pick(n, m_ptr[d]);
                m_cnt[d] = 0;
            end else begin
                m_busy[d] = 0;
            end
        end else begin
            m_to[d] = 0;
            if (m_cnt[d] < 255) m_cnt[d]++;
        end
    endtask

    function automatic exp_t model_out(input int d);
        exp_t e;
        e.sel     = 4'(m_sel[d]);
        e.valid   = (m_busy[d] != 0);
        e.grant   = (m_busy[d] != 0) ? (16'(1) << m_sel[d]) : 16'd0;
        e.timeout = (m_to[d] != 0);
        return e;
    endfunction

    function automatic exp_t observe(input int d);
        exp_t o;
        if (d == 0) begin
            o.sel = bus0.sel; o.valid = bus0.valid; o.grant = bus0.grant; o.timeout = bus0.timeout;
        end else begin
            o.sel = bus1.sel; o.valid = bus1.valid; o.grant = bus1.grant; o.timeout = bus1.timeout;
        end
        return o;
    endfunction

    // One clock: model advances on the edge, DUT outputs are checked on the falling edge.
    task automatic cycle();
        exp_t e;
        exp_t a;
        @(posedge clock);
        for (int d = 0; d < 2; d++) begin
            model_step(d);
            sb_q.push_back(model_out(d));
        end
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            a = observe(d);
            if (sb_q.size() == 0) begin
                chk($sformatf("d%0d_sb_empty", d), 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("d%0d_sel", d),     32'(a.sel),     32'(e.sel));
                chk($sformatf("d%0d_valid", d),   32'(a.valid),   32'(e.valid));
                chk($sformatf("d%0d_grant", d),   32'(a.grant),   32'(e.grant));
                chk($sformatf("d%0d_timeout", d), 32'(a.timeout), 32'(e.timeout));
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sel0"},   32'(bus0.sel),     32'd0);
        chk({tag, "_vld0"},   32'(bus0.valid),   32'd0);
        chk({tag, "_gnt0"},   32'(bus0.grant),   32'd0);
        chk({tag, "_to0"},    32'(bus0.timeout), 32'd0);
        chk({tag, "_sel1"},   32'(bus1.sel),     32'd0);
        chk({tag, "_vld1"},   32'(bus1.valid),   32'd0);
        chk({tag, "_gnt1"},   32'(bus1.grant),   32'd0);
        chk({tag, "_to1"},    32'(bus1.timeout), 32'd0);
    endtask

    int t1_sel [4] = '{0, 15, 0, 15};
    int t1_gnt [4] = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};
    int t2_vld [4] = '{1, 0, 1, 0};
    int t3_sel [10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
    int t3_to  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};

    initial begin
        req     = 16'd0;
        ready   = 1'b0;
        reset_n = 1'b1;
        model_reset();
        #1 reset_n = 1'b0;
        #3 chk_zero("reset");
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Two requesters at both ends of the ring, continuous accept.
        req = 16'h8001; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t1_sel",   32'(bus1.sel),   32'(t1_sel[i]));
            chk("t1_grant", 32'(bus1.grant), 32'(t1_gnt[i]));
            chk("t1_valid", 32'(bus1.valid), 32'd1);
        end
        req = 16'h0000;
        cycle();

        // Sole requester: granted every other cycle.
        req = 16'h0010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t2_valid", 32'(bus1.valid), 32'(t2_vld[i]));
            if (t2_vld[i] == 1) begin
                chk("t2_sel",   32'(bus1.sel),   32'd4);
                chk("t2_grant", 32'(bus1.grant), 32'h0010);
            end
        end

        // Stall timeout hand-over on the TIMEOUT=4 instance.
        req = 16'h0006; ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t3_sel",     32'(bus0.sel),     32'(t3_sel[i]));
            chk("t3_timeout", 32'(bus0.timeout), 32'(t3_to[i]));
            chk("t3_valid",   32'(bus0.valid),   32'd1);
        end
        req = 16'h0000; ready = 1'b1;
        cycle();

        // ready arriving in the cycle the timeout would fire: plain accept, no pulse.
        req = 16'h0006; ready = 1'b0;
        cycle();
        chk("t4_sel_first", 32'(bus0.sel), 32'd2);
        cycle();
        cycle();
        cycle();
        ready = 1'b1;
        cycle();
        chk("t4_sel_next", 32'(bus0.sel),     32'd1);
        chk("t4_no_pulse", 32'(bus0.timeout), 32'd0);
        req = 16'h0000;
        cycle();

        // Requester drops while stalled: grant is held until accepted.
        req = 16'h0008; ready = 1'b0;
        cycle();
        req = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t5_sel",   32'(bus1.sel),   32'd3);
            chk("t5_valid", 32'(bus1.valid), 32'd1);
            chk("t5_grant", 32'(bus1.grant), 32'h0008);
        end
        ready = 1'b1;
        cycle();
        chk("t5_idle_valid", 32'(bus1.valid), 32'd0);
        chk("t5_idle_grant", 32'(bus1.grant), 32'd0);

        // Asynchronous reset in the middle of a grant.
        req = 16'h0080; ready = 1'b0;
        cycle();
        chk("t6_sel_pre", 32'(bus1.sel), 32'd7);
        #2 reset_n = 1'b0;
        #1 chk_zero("t6_async");
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cycle();
        chk("t6_valid_post", 32'(bus1.valid), 32'd1);
        chk("t6_sel_post",   32'(bus1.sel),   32'd7);

        // Random traffic, both instances against the model.
        for (int i = 0; i < 300; i++) begin
            req   = 16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535));
            ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
